// File: rtl/meter_countdown.sv
// meter_countdown: BCD countdown meter with digit-serial add, tick prescaler
// and a multiplexed active-low 7-segment display driver.
// Optional feature macro: METER_BLINK_EN (display blinking on low/expired time).
module meter_countdown #(
    parameter int          DIGITS   = 4,
    parameter int          CLK_HZ   = 100000000,
    parameter int          TICK_HZ  = 1,
    parameter int          SCAN_DIV = 100000,
    parameter logic [31:0] LOW_BCD  = 32'h0000_0010
) (
    input  logic                  clk,
    input  logic                  btn_reset,
    input  logic                  add_valid,
    input  logic [4*DIGITS-1:0]   add_bcd,
    output logic                  add_ready,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic                  tick,
    output logic                  expired,
    output logic                  low_time,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int TW       = 4 * DIGITS;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW       = $clog2(DIGITS);
    localparam logic [TW-1:0] LOW_V     = TW'(LOW_BCD);
    localparam logic [TW-1:0] ALL_NINES = {DIGITS{4'd9}};
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ADD = 1'b1} state_t;

    // Digits above 9 are not legal BCD; treat them as 9.
    function automatic logic [TW-1:0] clamp_bcd(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
            else                    r[4*i +: 4] = v[4*i +: 4];
        end
        return r;
    endfunction

    // Subtract one BCD unit with borrow; zero stays at zero.
    function automatic logic [TW-1:0] dec_bcd(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = (v != {TW{1'b0}});
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Hex digit to active-low segments, bit order g..a.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] time_q, time_d;
    logic [TW-1:0] add_q, add_d;
    logic [TW-1:0] sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          pend_q, pend_d;
    logic          add_ready_q, expired_q, low_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [IW-1:0] scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [4:0]    dsum_s;
    logic [3:0]    dres_s, sel_dig_s;
    logic          dcarry_s, blank_s;
    logic [TW-1:0] sum_full_s;

    // One digit of the serial adder: current time digit + operand digit + carry.
    always_comb begin
        dsum_s = {1'b0, time_q[{idx_q, 2'b00} +: 4]} + {1'b0, add_q[{idx_q, 2'b00} +: 4]}
               + {4'd0, carry_q};
        if (dsum_s > 5'd9) begin
            dres_s   = 4'(dsum_s - 5'd10);
            dcarry_s = 1'b1;
        end else begin
            dres_s   = dsum_s[3:0];
            dcarry_s = 1'b0;
        end
        sum_full_s = sum_q;
        sum_full_s[{idx_q, 2'b00} +: 4] = dres_s;
    end

    // Next state of the add/decrement FSM and its datapath.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        add_d   = add_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                // a tick deferred from the last add counts like a live tick
                if (tick_q || pend_q) time_d = dec_bcd(time_q);
                else                  time_d = time_q;
                if (add_valid) begin
                    state_d = S_ADD;
                    add_d   = clamp_bcd(add_bcd);
                    sum_d   = {TW{1'b0}};
                    carry_d = 1'b0;
                    idx_d   = {IW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                if (tick_q) pend_d = 1'b1;
                else        pend_d = pend_q;
                sum_d   = sum_full_s;
                carry_d = dcarry_s;
                if (idx_q == IDX_MAX) begin
                    state_d = S_IDLE;
                    idx_d   = {IW{1'b0}};
                    if (dcarry_s) time_d = ALL_NINES;
                    else          time_d = sum_full_s;
                end else begin
                    state_d = S_ADD;
                    idx_d   = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Prescaler, scan counter and display select/decoding.
    always_comb begin
        if (presc_q == PRESC_MAX) presc_d = {PW{1'b0}};
        else                      presc_d = presc_q + PW'(1);
        tick_d = (presc_q == PRESC_MAX);
        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = {SW{1'b0}};
            if (scan_idx_q == IDX_MAX) scan_idx_d = {IW{1'b0}};
            else                       scan_idx_d = scan_idx_q + IW'(1);
        end else begin
            scan_cnt_d = scan_cnt_q + SW'(1);
            scan_idx_d = scan_idx_q;
        end
        sel_dig_s = time_d[{scan_idx_d, 2'b00} +: 4];
        if (int'(scan_idx_d) == 2) seg_d = {1'b0, hex7(sel_dig_s)};
        else                       seg_d = {1'b1, hex7(sel_dig_s)};
        if (blank_s) an_d = {DIGITS{1'b1}};
        else         an_d = ~(DIGITS'(1) << scan_idx_d);
    end

`ifdef METER_BLINK_EN
    localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);
    logic blink_q;

    // Blink phase flips on every tick.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) blink_q <= 1'b0;
        else if (tick_q) blink_q <= ~blink_q;
        else             blink_q <= blink_q;
    end

    assign blank_s = (expired_q && (presc_q < HALF)) || (low_q && blink_q);
`else
    assign blank_s = 1'b0;
`endif

    // FSM state, time value and derived status flags.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            state_q     <= S_IDLE;
            time_q      <= {TW{1'b0}};
            add_q       <= {TW{1'b0}};
            sum_q       <= {TW{1'b0}};
            carry_q     <= 1'b0;
            idx_q       <= {IW{1'b0}};
            pend_q      <= 1'b0;
            add_ready_q <= 1'b1;
            expired_q   <= 1'b1;
            low_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            add_q       <= add_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            add_ready_q <= (state_d == S_IDLE);
            expired_q   <= (time_q == {TW{1'b0}});
            low_q       <= (time_q != {TW{1'b0}}) && (time_q < LOW_V);
        end
    end

    // Tick prescaler and display scan registers.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            presc_q    <= {PW{1'b0}};
            tick_q     <= 1'b0;
            scan_cnt_q <= {SW{1'b0}};
            scan_idx_q <= {IW{1'b0}};
            an_q       <= ~(DIGITS'(1));
            seg_q      <= {1'b1, hex7(4'd0)};
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign add_ready = add_ready_q;
    assign time_bcd  = time_q;
    assign tick      = tick_q;
    assign expired   = expired_q;
    assign low_time  = low_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_meter_countdown.sv
// Bench for meter_countdown with DIGITS=4, CLK_HZ=20, TICK_HZ=1, SCAN_DIV=2.
module tb_meter_countdown;

    logic        clk = 1'b0;
    logic        btn_reset;
    logic        add_valid = 1'b0;
    logic [15:0] add_bcd = 16'h0000;
    logic        add_ready, tick, expired, low_time;
    logic [15:0] time_bcd;
    logic [7:0]  seg;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;
    int ntick = 0;
    bit chk_en = 1'b0;

    meter_countdown #(
        .DIGITS(4), .CLK_HZ(20), .TICK_HZ(1), .SCAN_DIV(2), .LOW_BCD(32'h0000_0010)
    ) dut (
        .clk(clk), .btn_reset(btn_reset), .add_valid(add_valid), .add_bcd(add_bcd),
        .add_ready(add_ready), .time_bcd(time_bcd), .tick(tick), .expired(expired),
        .low_time(low_time), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // Behavioural model: time as a decimal integer, add modelled as a busy window.
    typedef struct {
        int t;       // remaining time, decimal
        int prev_t;  // time one cycle earlier (status flags lag by one)
        int busy;    // cycles of add still in progress
        int amt;     // decimal amount being added
        bit pend;    // tick waiting for the add to finish
        int cyc;     // clock edges since reset release
    } mdl_t;

    mdl_t m;

    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int clamp_dec(input logic [15:0] ab);
        int r, w;
        logic [3:0] d;
        r = 0; w = 1;
        for (int k = 0; k < 4; k++) begin
            d = ab[4*k +: 4];
            if (d > 4'd9) d = 4'd9;
            r = r + int'(d) * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic mdl_t model_next(input mdl_t c, input logic av, input logic [15:0] ab);
        mdl_t n;
        bit   tk;
        n = c;
        n.prev_t = c.t;
        n.cyc = c.cyc + 1;
        tk = (c.cyc != 0) && (c.cyc % 20 == 0);
        if (c.busy == 0) begin
            if (tk || c.pend) n.t = (c.t > 0) ? c.t - 1 : 0;
            n.pend = 1'b0;
            if (av) begin
                n.amt  = clamp_dec(ab);
                n.busy = 4;
            end
        end else begin
            if (tk) n.pend = 1'b1;
            n.busy = c.busy - 1;
            if (n.busy == 0) n.t = (c.t + c.amt > 9999) ? 9999 : c.t + c.amt;
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_seg(input mdl_t s);
        int idx, d;
        logic [7:0] r;
        idx = (s.cyc / 2) % 4;
        d = s.t;
        for (int k = 0; k < idx; k++) d = d / 10;
        r = seg_tbl[d % 10];
        if (idx == 2) r[7] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] exp_an(input mdl_t s);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((s.cyc / 2) % 4));
    endfunction

    // model state advances on each clock edge, clears on async reset
    always @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) m <= '{t: 0, prev_t: 0, busy: 0, amt: 0, pend: 1'b0, cyc: 0};
        else            m <= model_next(m, add_valid, add_bcd);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, m.cyc);
        end
    endtask

    // compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en && btn_reset) begin
            chk("time_bcd", time_bcd, to_bcd(m.t));
            chk("tick", tick, (m.cyc != 0) && (m.cyc % 20 == 0));
            chk("add_ready", add_ready, m.busy == 0);
            chk("expired", expired, m.prev_t == 0);
            chk("low_time", low_time, (m.prev_t > 0) && (m.prev_t < 10));
            chk("seg", seg, exp_seg(m));
`ifndef METER_BLINK_EN
            chk("an", an, exp_an(m));
`endif
        end
    end

    task automatic wait_phase(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (m.cyc % 20 == p) hit = 1'b1;
        end
        chk("phase_reached", hit, 1);
    endtask

    task automatic do_add(input logic [15:0] v);
        add_bcd   = v;
        add_valid = 1'b1;
        @(negedge clk);
        add_valid = 1'b0;
        add_bcd   = 16'h0000;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 btn_reset = 1'b0;
        #1;
        chk("rst_time", time_bcd, 16'h0000);
        chk("rst_ready", add_ready, 1);
        chk("rst_expired", expired, 1);
        chk("rst_low", low_time, 0);
        chk("rst_tick", tick, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 8'hC0);
        @(negedge clk);
        #2 btn_reset = 1'b1;
    endtask

    initial begin
        btn_reset = 1'b1;
        #1 btn_reset = 1'b0;
        reset_pulse();
        chk_en = 1'b1;

        // idle after reset: ticks at cycles 20 and 40, time stays 0000
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (tick) ntick++;
        end
        chk("idle_ticks", ntick, 2);
        chk("idle_time", time_bcd, 16'h0000);
        chk("idle_expired", expired, 1);

        // add 0012 then count down into the low-time range
        wait_phase(1);
        do_add(16'h0012);
        chk("add_busy", add_ready, 0);
        repeat (4) @(negedge clk);
        chk("add12_time", time_bcd, 16'h0012);
        chk("add12_ready", add_ready, 1);
        wait_phase(2);
        chk("dec_0011", time_bcd, 16'h0011);
        chk("low_at_11", low_time, 0);
        wait_phase(2);
        chk("dec_0010", time_bcd, 16'h0010);
        wait_phase(2);
        chk("dec_0009", time_bcd, 16'h0009);
        chk("low_at_9", low_time, 1);

        // 0009 + 0091 = 0100, then borrow across digits to 0099
        wait_phase(3);
        do_add(16'h0091);
        repeat (4) @(negedge clk);
        chk("add_to_0100", time_bcd, 16'h0100);
        wait_phase(2);
        chk("borrow_0099", time_bcd, 16'h0099);

        // 0001 counts to 0000 and stays there
        reset_pulse();
        wait_phase(1);
        do_add(16'h0001);
        wait_phase(2);
        chk("to_zero", time_bcd, 16'h0000);
        chk("zero_expired", expired, 1);
        wait_phase(2);
        chk("stay_zero", time_bcd, 16'h0000);

        // saturation and digit clamping
        reset_pulse();
        wait_phase(1);
        do_add(16'h9990);
        repeat (4) @(negedge clk);
        chk("add_9990", time_bcd, 16'h9990);
        wait_phase(7);
        do_add(16'h0025);
        repeat (4) @(negedge clk);
        chk("saturate", time_bcd, 16'h9999);
        reset_pulse();
        wait_phase(1);
        do_add(16'h00A5);
        repeat (4) @(negedge clk);
        chk("clamp_A5", time_bcd, 16'h0095);

        // tick during an add is deferred to the first idle cycle
        reset_pulse();
        wait_phase(1);
        do_add(16'h0010);
        wait_phase(17);
        do_add(16'h0005);
        repeat (4) @(negedge clk);
        chk("mid_add_sum", time_bcd, 16'h0015);
        @(negedge clk);
        chk("pending_dec", time_bcd, 16'h0014);

        // tick on the accept cycle decrements the base first: 14-1+3
        wait_phase(0);
        do_add(16'h0003);
        repeat (4) @(negedge clk);
        chk("accept_tick", time_bcd, 16'h0016);

        // reset in the second add cycle aborts the add
        wait_phase(1);
        do_add(16'h0100);
        @(negedge clk);
        chk("abort_busy", add_ready, 0);
        #2 btn_reset = 1'b0;
        #1;
        chk("abort_time", time_bcd, 16'h0000);
        chk("abort_ready", add_ready, 1);
        @(negedge clk);
        #2 btn_reset = 1'b1;
        repeat (25) @(negedge clk);
        chk("after_abort", time_bcd, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
